// File: rtl/div_seq_param_if.sv
// Handshake/result bundle for the sequential divider.
interface div_seq_param_if #(
    parameter int NUM_W = 8,
    parameter int DEN_W = 4
);
    localparam int Q_W = NUM_W - DEN_W;

    logic             start;
    logic [NUM_W-1:0] num;
    logic [DEN_W-1:0] denom;
    logic [Q_W-1:0]   quotient;
    logic [DEN_W-1:0] remainder;
    logic             rdy;
    logic             overflow;
    logic             busy;

    modport master (
        output start, num, denom,
        input  quotient, remainder, rdy, overflow, busy
    );

    modport slave (
        input  start, num, denom,
        output quotient, remainder, rdy, overflow, busy
    );
endinterface

// File: rtl/div_seq_param.sv
// Sequential restoring divider, one quotient bit per cycle, MSB first.
// Define DIV_SIGNED_EN for two's-complement operands (adds a FIX cycle).
module div_seq_param #(
    parameter int NUM_W = 8,
    parameter int DEN_W = 4
) (
    input  logic          clk,
    input  logic          rst,
    div_seq_param_if.slave bus
);
    localparam int Q_W   = NUM_W - DEN_W;
    localparam int CNT_W = $clog2(Q_W + 1);

`ifdef DIV_SIGNED_EN
    typedef enum logic [2:0] {IDLE, CHECK, ITER, FIX, DONE} state_t;
    localparam logic [Q_W-1:0] Q_HALF = Q_W'(1) << (Q_W - 1);
`else
    typedef enum logic [2:0] {IDLE, CHECK, ITER, DONE} state_t;
`endif

    state_t           state_q, state_d;
    logic [NUM_W-1:0] num_q, num_d;
    logic [DEN_W-1:0] den_q, den_d;
    logic [DEN_W-1:0] rem_q, rem_d;
    logic [Q_W-1:0]   qsh_q, qsh_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             ovf_q, ovf_d;
    logic [Q_W-1:0]   quo_q, quo_d;
    logic [DEN_W-1:0] remo_q, remo_d;
    logic             ovfo_q, ovfo_d;
    logic             rdy_q, rdy_d;
    logic             busy_q, busy_d;

    logic [NUM_W-1:0] mag_num;
    logic [DEN_W-1:0] mag_den;
    logic [DEN_W:0]   shifted, diff;
    logic             qbit;
    logic             accept;

`ifdef DIV_SIGNED_EN
    logic signed [NUM_W-1:0] num_s;
    logic signed [DEN_W-1:0] den_s;
    logic                    q_neg;
    assign num_s   = num_q;
    assign den_s   = den_q;
    assign mag_num = (num_s < 0) ? NUM_W'(-num_s) : num_q;
    assign mag_den = (den_s < 0) ? DEN_W'(-den_s) : den_q;
    assign q_neg   = num_q[NUM_W-1] ^ den_q[DEN_W-1];
`else
    assign mag_num = num_q;
    assign mag_den = den_q;
`endif

    // busy_q is low only in IDLE or in DONE after the result is published
    assign accept = bus.start && !busy_q;

    always_comb begin
        state_d = state_q;
        num_d   = num_q;
        den_d   = den_q;
        rem_d   = rem_q;
        qsh_d   = qsh_q;
        cnt_d   = cnt_q;
        ovf_d   = ovf_q;
        quo_d   = quo_q;
        remo_d  = remo_q;
        ovfo_d  = ovfo_q;
        rdy_d   = rdy_q;
        busy_d  = busy_q;
        shifted = {rem_q, qsh_q[Q_W-1]};
        diff    = shifted - {1'b0, mag_den};
        qbit    = (shifted >= {1'b0, mag_den});

        case (state_q)
            IDLE: ;
            CHECK: begin
                if (den_q == '0 || mag_num[NUM_W-1:Q_W] >= mag_den) begin
                    ovf_d   = 1'b1;
                    state_d = DONE;
                end else begin
                    ovf_d   = 1'b0;
                    rem_d   = mag_num[NUM_W-1:Q_W];
                    qsh_d   = mag_num[Q_W-1:0];
                    cnt_d   = '0;
                    state_d = ITER;
                end
            end
            ITER: begin
                rem_d = qbit ? diff[DEN_W-1:0] : shifted[DEN_W-1:0];
                qsh_d = (qsh_q << 1) | Q_W'(qbit);
                cnt_d = cnt_q + 1'b1;
                if (cnt_q == CNT_W'(Q_W - 1)) begin
`ifdef DIV_SIGNED_EN
                    state_d = FIX;
`else
                    state_d = DONE;
`endif
                end
            end
`ifdef DIV_SIGNED_EN
            FIX: begin
                // magnitude limit is one larger on the negative side
                ovf_d   = q_neg ? (qsh_q > Q_HALF) : (qsh_q >= Q_HALF);
                qsh_d   = q_neg ? (~qsh_q + 1'b1) : qsh_q;
                rem_d   = num_q[NUM_W-1] ? (~rem_q + 1'b1) : rem_q;
                state_d = DONE;
            end
`endif
            DONE: begin
                if (busy_q) begin
                    rdy_d  = 1'b1;
                    busy_d = 1'b0;
                    ovfo_d = ovf_q;
                    quo_d  = ovf_q ? '1 : qsh_q;
                    remo_d = ovf_q ? '0 : rem_q;
                end
            end
            default: state_d = IDLE;
        endcase

        if (accept) begin
            num_d   = bus.num;
            den_d   = bus.denom;
            rdy_d   = 1'b0;
            busy_d  = 1'b1;
            state_d = CHECK;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= IDLE;
            num_q   <= '0;
            den_q   <= '0;
            rem_q   <= '0;
            qsh_q   <= '0;
            cnt_q   <= '0;
            ovf_q   <= 1'b0;
            quo_q   <= '0;
            remo_q  <= '0;
            ovfo_q  <= 1'b0;
            rdy_q   <= 1'b0;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            num_q   <= num_d;
            den_q   <= den_d;
            rem_q   <= rem_d;
            qsh_q   <= qsh_d;
            cnt_q   <= cnt_d;
            ovf_q   <= ovf_d;
            quo_q   <= quo_d;
            remo_q  <= remo_d;
            ovfo_q  <= ovfo_d;
            rdy_q   <= rdy_d;
            busy_q  <= busy_d;
        end
    end

    assign bus.quotient  = quo_q;
    assign bus.remainder = remo_q;
    assign bus.overflow  = ovfo_q;
    assign bus.rdy       = rdy_q;
    assign bus.busy      = busy_q;
endmodule

// File: tb/tb_div_seq_param.sv
// Scoreboard bench for div_seq_param: reference division model feeds a queue
// that is drained whenever rdy rises.
module tb_div_seq_param;
    localparam int NUM_W = 8;
    localparam int DEN_W = 4;
    localparam int Q_W   = NUM_W - DEN_W;

    typedef struct {
        logic [Q_W-1:0]   q;
        logic [DEN_W-1:0] r;
        logic             ovf;
        int               lat;
    } exp_t;

    logic clk = 1'b0;
    logic rst;
    int   n_checks = 0;
    int   n_errors = 0;
    logic rdy_prev = 1'b0;
    exp_t sb[$];

    div_seq_param_if #(.NUM_W(NUM_W), .DEN_W(DEN_W)) bus ();

    div_seq_param #(.NUM_W(NUM_W), .DEN_W(DEN_W)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    task automatic chk_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic exp_t model(input logic [NUM_W-1:0] n, input logic [DEN_W-1:0] d);
        exp_t e;
        int ni, di, qi, ri, qa;
        e.ovf = 1'b0;
        e.q   = '1;
        e.r   = '0;
`ifdef DIV_SIGNED_EN
        ni = int'($signed(n));
        di = int'($signed(d));
`else
        ni = int'(n);
        di = int'(d);
`endif
        if (di == 0) begin
            e.ovf = 1'b1;
            e.lat = 2;
        end else begin
            qi = ni / di;
            ri = ni % di;
            qa = (qi < 0) ? -qi : qi;
            if (qa >= (1 << Q_W)) begin
                e.ovf = 1'b1;
                e.lat = 2;
            end else begin
`ifdef DIV_SIGNED_EN
                e.lat = Q_W + 3;
                e.ovf = (qi > (1 << (Q_W - 1)) - 1) || (qi < -(1 << (Q_W - 1)));
`else
                e.lat = Q_W + 2;
`endif
                if (!e.ovf) begin
                    e.q = Q_W'(qi);
                    e.r = DEN_W'(ri);
                end
            end
        end
        return e;
    endfunction

    always @(negedge clk) begin
        if (bus.rdy && !rdy_prev) begin
            if (sb.size() == 0) begin
                chk_eq("rdy_without_request", 32'(bus.rdy), 32'd0);
            end else begin
                exp_t e;
                e = sb.pop_front();
                chk_eq("mon_quotient", 32'(bus.quotient), 32'(e.q));
                chk_eq("mon_remainder", 32'(bus.remainder), 32'(e.r));
                chk_eq("mon_overflow", 32'(bus.overflow), 32'(e.ovf));
                chk_eq("mon_busy", 32'(bus.busy), 32'd0);
            end
        end
        rdy_prev = bus.rdy;
    end

    // One request with latency check; poke>0 pulses a competing start at that edge.
    task automatic run_op(input logic [NUM_W-1:0] n, input logic [DEN_W-1:0] d, input int poke);
        exp_t e;
        int   cnt;
        logic seen;
        e = model(n, d);
        @(negedge clk);
        bus.start = 1'b1;
        bus.num   = n;
        bus.denom = d;
        sb.push_back(e);
        @(posedge clk);
        #1;
        bus.start = 1'b0;
        bus.num   = ~n;
        bus.denom = ~d;
        chk_eq("rdy_low_after_accept", 32'(bus.rdy), 32'd0);
        chk_eq("busy_after_accept", 32'(bus.busy), 32'd1);
        cnt  = 0;
        seen = 1'b0;
        while (!seen && cnt < 64) begin
            if (cnt == poke - 1) begin
                bus.start = 1'b1;
                bus.num   = 8'd9;
                bus.denom = 4'd3;
            end
            if (cnt == poke) bus.start = 1'b0;
            @(posedge clk);
            #1;
            cnt++;
            seen = bus.rdy;
        end
        bus.start = 1'b0;
        chk_eq("latency", 32'(cnt), 32'(e.lat));
        @(negedge clk);
    endtask

    initial begin
        int g;
        bus.start = 1'b0;
        bus.num   = '0;
        bus.denom = '0;
        rst = 1'b1;
        #1 rst = 1'b0;
        #2;
        chk_eq("rst_quotient", 32'(bus.quotient), 32'd0);
        chk_eq("rst_remainder", 32'(bus.remainder), 32'd0);
        chk_eq("rst_rdy", 32'(bus.rdy), 32'd0);
        chk_eq("rst_overflow", 32'(bus.overflow), 32'd0);
        chk_eq("rst_busy", 32'(bus.busy), 32'd0);
        repeat (2) @(negedge clk);
        rst = 1'b1;

        run_op(8'd100, 4'd7, -1);
        run_op(8'h55, 4'd0, -1);
        run_op(8'hF0, 4'hF, -1);
        run_op(8'd100, 4'd7, 3);
`ifndef DIV_SIGNED_EN
        chk_eq("ignored_start_q", 32'(bus.quotient), 32'hE);
        chk_eq("ignored_start_r", 32'(bus.remainder), 32'h2);
        repeat (3) @(posedge clk);
        #1;
        chk_eq("hold_rdy", 32'(bus.rdy), 32'd1);
        chk_eq("hold_quotient", 32'(bus.quotient), 32'hE);
        chk_eq("hold_remainder", 32'(bus.remainder), 32'h2);
`else
        run_op(8'hCE, 4'd7, -1);
        chk_eq("signed_q", 32'(bus.quotient), 32'h9);
        chk_eq("signed_r", 32'(bus.remainder), 32'hF);
        run_op(8'h80, 4'hF, -1);
        chk_eq("signed_ovf", 32'(bus.overflow), 32'd1);
`endif

        // abort mid-operation with asynchronous reset
        @(negedge clk);
        bus.start = 1'b1;
        bus.num   = 8'd100;
        bus.denom = 4'd7;
        @(posedge clk);
        #1 bus.start = 1'b0;
        repeat (3) @(posedge clk);
        #2 rst = 1'b0;
        #1;
        chk_eq("abort_quotient", 32'(bus.quotient), 32'd0);
        chk_eq("abort_remainder", 32'(bus.remainder), 32'd0);
        chk_eq("abort_rdy", 32'(bus.rdy), 32'd0);
        chk_eq("abort_overflow", 32'(bus.overflow), 32'd0);
        chk_eq("abort_busy", 32'(bus.busy), 32'd0);
        repeat (2) @(negedge clk);
        rst = 1'b1;
        run_op(8'd9, 4'd3, -1);
        chk_eq("after_abort_q", 32'(bus.quotient), 32'h3);
        chk_eq("after_abort_r", 32'(bus.remainder), 32'h0);

        // exhaustive sweep with start held high
        @(negedge clk);
        bus.start = 1'b1;
        for (int i = 0; i < (1 << (NUM_W + DEN_W)); i++) begin
            bus.num   = NUM_W'(i >> DEN_W);
            bus.denom = DEN_W'(i);
            sb.push_back(model(NUM_W'(i >> DEN_W), DEN_W'(i)));
            g = 0;
            while (bus.busy && g < 50) begin
                @(negedge clk);
                g++;
            end
            if (g >= 50) chk_eq("sweep_accept_timeout", 32'(bus.busy), 32'd0);
            @(posedge clk);
            #1;
        end
        bus.start = 1'b0;

        g = 0;
        while (sb.size() != 0 && g < 100) begin
            @(negedge clk);
            g++;
        end
        repeat (2) @(negedge clk);
        chk_eq("scoreboard_drained", 32'(sb.size()), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule

// File: doc/div_seq_param.md
DIV_SEQ_PARAM -- requirements
Module: div_seq_param

Interface
REQ-001 Parameter NUM_W, default 8, dividend width; legal range NUM_W > DEN_W.
REQ-002 Parameter DEN_W, default 4, divisor width; legal range DEN_W >= 2. Derived Q_W = NUM_W - DEN_W is the quotient width; remainder width is DEN_W.
REQ-003 clk  input  1  single clock, all state updates on rising edge.
REQ-004 rst  input  1  reset is asynchronous and active-low (asserted at 0).
REQ-005 start  input  1  request a division; sampled only when busy=0.
REQ-006 num  input  NUM_W  dividend, sampled on the accepting edge.
REQ-007 denom  input  DEN_W  divisor, sampled on the accepting edge.
REQ-008 quotient  output  Q_W  result quotient, registered.
REQ-009 remainder  output  DEN_W  result remainder, registered.
REQ-010 rdy  output  1  results valid; held until the next accepted start.
REQ-011 overflow  output  1  the last result was not representable; valid while rdy=1.
REQ-012 busy  output  1  operation in progress; start is ignored while busy=1.

Function
REQ-013 States: IDLE, CHECK, ITER, FIX (signed build only), DONE.
REQ-014 Accept: start=1 in IDLE or DONE on a rising edge -> operands latched, rdy<=0, busy<=1, next state CHECK. This is accept edge 0.
REQ-015 CHECK, one cycle: overflow if denom==0, or if num[NUM_W-1:Q_W] >= denom (unsigned, magnitudes in the signed build).
REQ-016 Overflow in CHECK -> DONE at edge 2: quotient = all ones, remainder = 0, overflow=1, rdy=1, busy=0.
REQ-017 No overflow -> ITER for exactly Q_W cycles of restoring shift-subtract, one quotient bit per cycle, MSB first.
REQ-018 Unsigned result: rdy=1 at edge Q_W+2 with quotient=num/denom and remainder=num%denom; overflow=0.
REQ-019 Outputs quotient, remainder and overflow change only on the edge that sets rdy=1. They hold otherwise, including after busy falls.
REQ-020 start=1 while busy=1 has no effect and is not queued.
REQ-021 start=1 in DONE on the same edge rdy would otherwise hold: the new operation is accepted and rdy falls on that edge.
REQ-022 start held high continuously: a new operation is accepted on every edge where busy=0.
REQ-023 Operand changes after the accepting edge do not affect the result.

Reset
REQ-024 rst=0 asynchronously forces: state IDLE, quotient=0, remainder=0, rdy=0, overflow=0, busy=0, internal registers cleared.
REQ-025 Reset asserted mid-operation aborts the operation; no rdy is produced for it.
REQ-026 The first accept is allowed on the first rising edge with rst=1.

Configuration
REQ-027 Macro DIV_SIGNED_EN. When undefined: operands and results are unsigned, there is no FIX state, and behaviour is per REQ-015..REQ-018.
REQ-028 When DIV_SIGNED_EN is defined, operands are two's complement and division runs on magnitudes. A FIX cycle then applies signs:
- quotient truncated toward zero;
- remainder takes the sign of the dividend.
rdy rises at edge Q_W+3.
REQ-029 With DIV_SIGNED_EN, FIX also flags overflow when the signed quotient falls outside [-2^(Q_W-1), 2^(Q_W-1)-1]. In that case the outputs are per REQ-016.

Verification (defaults NUM_W=8, DEN_W=4, unsigned unless noted)
REQ-030 num=100, denom=7 -> quotient=0xE, remainder=0x2, overflow=0, rdy rises exactly 6 edges after accept.
REQ-031 num=0x55, denom=0 -> overflow=1, quotient=0xF, remainder=0x0, rdy at edge 2; num=0xF0, denom=0xF -> overflow=1.
REQ-032 Exhaustive sweep of all 4096 num/denom pairs, back-to-back with start held high -> every result matches the reference division, or overflow=1 exactly when the quotient exceeds 0xF or denom=0.
REQ-033 Start num=100, denom=7; pulse start with num=9, denom=3 at edge 3 -> the second request is ignored and the result is still 0xE/0x2.
REQ-034 Start a division, drive rst=0 at edge 3 -> all outputs read 0 immediately, with no clock edge needed. After release, num=9, denom=3 -> 0x3/0x0.
REQ-035 DIV_SIGNED_EN: num=0xCE (-50), denom=7 -> quotient=0x9 (-7), remainder=0xF (-1), rdy at edge 7; num=0x80, denom=0xF (-1) -> overflow=1.
